// File: rtl/sppf_pkg.sv
// Shared types and constants for the SPPF 5x5 max-pool sequencer.
package sppf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMPUTE,
        EMIT,
        DONE
    } stateT;

    localparam int K    = 5;
    localparam int HALF = 2;
    localparam int TAPS = K * K;

    // Most negative two's-complement value of the given width, used for padded taps.
    function automatic logic [63:0] padPattern(int width);
        padPattern = 64'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/sppf_win_addr_gen.sv
// Maps an output pixel and a window tap index to a bounds flag and a RAM address.
module sppf_win_addr_gen
    import sppf_pkg::*;
#(
    parameter int MAP_H  = 20,
    parameter int MAP_W  = 20,
    parameter int ADDR_W = $clog2(MAP_H * MAP_W)
) (
    input  logic [ADDR_W-1:0] oy,
    input  logic [ADDR_W-1:0] ox,
    input  logic [4:0]        k,
    output logic              inBounds,
    output logic [ADDR_W-1:0] addr
);

    int dy;
    int dx;
    int y;
    int x;

    always_comb begin
        dy       = int'(k) / K;
        dx       = int'(k) % K;
        y        = int'(oy) + dy - HALF;
        x        = int'(ox) + dx - HALF;
        inBounds = (y >= 0) && (y < MAP_H) && (x >= 0) && (x < MAP_W);
        addr     = inBounds ? ADDR_W'(y * MAP_W + x) : '0;
    end

endmodule

// File: rtl/sppf_pool_ctrl.sv
// Sequences one channel of a stride-1, pad-2 5x5 max-pool: fetches each window,
// hands it to an external max unit and streams the registered result.
module sppf_pool_ctrl
    import sppf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAP_H      = 20,
    parameter int MAP_W      = 20,
    parameter int ADDR_W     = $clog2(MAP_H * MAP_W)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]        rd_data,
    output logic [0:TAPS*DATA_WIDTH-1]   win_data,
    input  logic [DATA_WIDTH-1:0]        max_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [ADDR_W-1:0]            out_addr
);

    localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(padPattern(DATA_WIDTH));

    stateT             state;
    logic [ADDR_W-1:0] oy;
    logic [ADDR_W-1:0] ox;
    logic [4:0]        k;
    logic [ADDR_W-1:0] pixAddr;
    logic              tagValid;
    logic [4:0]        tagK;
    logic              tagPad;

    logic              issue;
    logic [ADDR_W-1:0] genOy;
    logic [ADDR_W-1:0] genOx;
    logic [4:0]        genK;
    logic              genInBounds;
    logic [ADDR_W-1:0] genAddr;
    logic              lastPix;

    assign lastPix = (pixAddr == ADDR_W'(MAP_H * MAP_W - 1));

    // Look ahead to the tap fetched next cycle so rd_en/rd_addr can be registered.
    always_comb begin
        issue = 1'b0;
        genOy = oy;
        genOx = ox;
        genK  = k;
        case (state)
            IDLE: begin
                if (start) begin
                    issue = 1'b1;
                    genOy = '0;
                    genOx = '0;
                    genK  = '0;
                end
            end
            FETCH: begin
                if (k != 5'(TAPS - 1)) begin
                    issue = 1'b1;
                    genK  = k + 5'd1;
                end
            end
            EMIT: begin
                if (out_ready && !lastPix) begin
                    issue = 1'b1;
                    genK  = '0;
                    if (ox == ADDR_W'(MAP_W - 1)) begin
                        genOx = '0;
                        genOy = oy + ADDR_W'(1);
                    end else begin
                        genOx = ox + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    sppf_win_addr_gen #(
        .MAP_H  (MAP_H),
        .MAP_W  (MAP_W),
        .ADDR_W (ADDR_W)
    ) uAddrGen (
        .oy       (genOy),
        .ox       (genOx),
        .k        (genK),
        .inBounds (genInBounds),
        .addr     (genAddr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            oy        <= '0;
            ox        <= '0;
            k         <= '0;
            pixAddr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            tagValid  <= 1'b0;
            tagK      <= '0;
            tagPad    <= 1'b0;
            win_data  <= {TAPS{PAD}};
        end else begin
            done  <= 1'b0;
            rd_en <= issue && genInBounds;
            if (issue && genInBounds) begin
                rd_addr <= genAddr;
            end
            if (issue) begin
                oy <= genOy;
                ox <= genOx;
                k  <= genK;
            end

            // The tap fetched this cycle lands in its slot when its RAM data arrives.
            tagValid <= (state == FETCH);
            tagK     <= k;
            tagPad   <= !rd_en;
            if (tagValid) begin
                win_data[int'(tagK) * DATA_WIDTH +: DATA_WIDTH] <= tagPad ? PAD : rd_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        busy    <= 1'b1;
                        pixAddr <= '0;
                    end
                end
                FETCH: begin
                    if (k == 5'(TAPS - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: state <= COMPUTE;
                COMPUTE: begin
                    out_data  <= max_data;
                    out_addr  <= pixAddr;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (lastPix) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= FETCH;
                            pixAddr <= pixAddr + ADDR_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sppf_pool_ctrl.sv
// Directed bench: a 5x5 instance for value/timing/backpressure/reset scenarios and
// a default 20x20 instance for corner and edge padding.
module tb_sppf_pool_ctrl;

    localparam int DW = 16;
    localparam int SA = 5;
    localparam int LA = 9;

    logic clk;
    logic reset;

    logic              startS, busyS, doneS, rdEnS, validS, readyS;
    logic [SA-1:0]     rdAddrS, addrS;
    logic [DW-1:0]     rdDataS, maxS, dataS;
    logic [0:25*DW-1]  winS;

    logic              startL, busyL, doneL, rdEnL, validL, readyL;
    logic [LA-1:0]     rdAddrL, addrL;
    logic [DW-1:0]     rdDataL, maxL, dataL;
    logic [0:25*DW-1]  winL;

    logic [DW-1:0]     memS [32];
    logic [DW-1:0]     memL [512];
    logic [0:25*DW-1]  allPad;

    int nChecks = 0;
    int nFail   = 0;

    logic [DW-1:0] gotData [25];
    int            gotAddr [25];
    int            gotCyc  [25];
    int            nOut, doneCnt, doneCyc;
    logic          busyFirst, busyAtDone;

    sppf_pool_ctrl #(.DATA_WIDTH(DW), .MAP_H(5), .MAP_W(5)) dutS (
        .clk(clk), .reset(reset), .start(startS), .busy(busyS), .done(doneS),
        .rd_en(rdEnS), .rd_addr(rdAddrS), .rd_data(rdDataS), .win_data(winS),
        .max_data(maxS), .out_valid(validS), .out_ready(readyS),
        .out_data(dataS), .out_addr(addrS)
    );

    sppf_pool_ctrl #(.DATA_WIDTH(DW)) dutL (
        .clk(clk), .reset(reset), .start(startL), .busy(busyL), .done(doneL),
        .rd_en(rdEnL), .rd_addr(rdAddrL), .rd_data(rdDataL), .win_data(winL),
        .max_data(maxL), .out_valid(validL), .out_ready(readyL),
        .out_data(dataL), .out_addr(addrL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous feature-map RAMs, one-cycle read latency.
    always @(posedge clk) begin
        if (rdEnS) rdDataS <= memS[rdAddrS];
        if (rdEnL) rdDataL <= memL[rdAddrL];
    end

    // External combinational signed max units.
    always_comb begin
        maxS = winS[0 +: DW];
        for (int t = 1; t < 25; t++)
            if ($signed(winS[t*DW +: DW]) > $signed(maxS)) maxS = winS[t*DW +: DW];
    end

    always_comb begin
        maxL = winL[0 +: DW];
        for (int t = 1; t < 25; t++)
            if ($signed(winL[t*DW +: DW]) > $signed(maxL)) maxL = winL[t*DW +: DW];
    end

    // Ramp map 0..24: the window max is the bottom-right in-bounds element.
    function automatic logic [DW-1:0] expRamp(int a);
        int ry, rx;
        ry = a / 5 + 2;
        rx = a % 5 + 2;
        if (ry > 4) ry = 4;
        if (rx > 4) rx = 4;
        return DW'(ry * 5 + rx);
    endfunction

    // Single 7FFF at (3,3) among 8000: visible within Chebyshev distance 2.
    function automatic logic [DW-1:0] expPeak(int a);
        int py, px;
        py = a / 5;
        px = a % 5;
        if (py - 3 <= 2 && 3 - py <= 2 && px - 3 <= 2 && 3 - px <= 2) return 16'h7FFF;
        return 16'h8000;
    endfunction

    // Runs one full pass on the 5x5 instance from the current negedge, recording outputs.
    task runPassS(input int budget);
        nOut = 0; doneCnt = 0; doneCyc = -1; busyFirst = 1'bx; busyAtDone = 1'bx;
        for (int i = 0; i < 25; i++) begin
            gotData[i] = 'x; gotAddr[i] = -1; gotCyc[i] = -1;
        end
        startS = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            startS = 1'b0;
            if (n == 1) busyFirst = busyS;
            if (validS && readyS) begin
                if (nOut < 25) begin
                    gotData[nOut] = dataS; gotAddr[nOut] = int'(addrS); gotCyc[nOut] = n;
                end
                nOut++;
            end
            if (doneS) begin
                doneCnt++;
                if (doneCyc < 0) begin doneCyc = n; busyAtDone = busyS; end
            end
            if (doneCyc >= 0 && n >= doneCyc + 2) break;
        end
    endtask

    task test_reset;
        reset = 1'b1; startS = 1'b0; startL = 1'b0; readyS = 1'b1; readyL = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++; if (busyS !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busyS); end
        nChecks++; if (doneS !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b want 0", doneS); end
        nChecks++; if (rdEnS !== 1'b0) begin nFail++; $display("FAIL reset_rd_en: got %b want 0", rdEnS); end
        nChecks++; if (validS !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", validS); end
        nChecks++; if (dataS !== 16'h0) begin nFail++; $display("FAIL reset_out_data: got %h want 0", dataS); end
        nChecks++; if (addrS !== 5'd0) begin nFail++; $display("FAIL reset_out_addr: got %0d want 0", addrS); end
        nChecks++; if (rdAddrS !== 5'd0) begin nFail++; $display("FAIL reset_rd_addr: got %0d want 0", rdAddrS); end
        nChecks++; if (winS !== allPad) begin nFail++; $display("FAIL reset_win: got %h want all 8000", winS); end
        nChecks++; if (winL !== allPad) begin nFail++; $display("FAIL reset_win_l: got %h want all 8000", winL); end
        nChecks++; if (busyL !== 1'b0 || validL !== 1'b0) begin nFail++; $display("FAIL reset_l: busy %b valid %b want 0 0", busyL, validL); end
        reset = 1'b0;
        @(negedge clk);
        nChecks++; if (busyS !== 1'b0) begin nFail++; $display("FAIL idle_busy: got %b want 0", busyS); end
    endtask

    task test_window_values;
        for (int i = 0; i < 32; i++) memS[i] = DW'(i);
        readyS = 1'b1;
        runPassS(800);
        nChecks++; if (nOut !== 25) begin nFail++; $display("FAIL ramp_count: got %0d want 25", nOut); end
        for (int i = 0; i < 25; i++) begin
            nChecks++; if (gotAddr[i] !== i) begin nFail++; $display("FAIL ramp_addr[%0d]: got %0d want %0d", i, gotAddr[i], i); end
            nChecks++; if (gotData[i] !== expRamp(i)) begin nFail++; $display("FAIL ramp_data[%0d]: got %0d want %0d", i, gotData[i], expRamp(i)); end
        end
        nChecks++; if (gotData[0] !== 16'd12) begin nFail++; $display("FAIL ramp_00: got %0d want 12", gotData[0]); end
        nChecks++; if (gotData[12] !== 16'd24) begin nFail++; $display("FAIL ramp_22: got %0d want 24", gotData[12]); end
        nChecks++; if (gotData[24] !== 16'd24) begin nFail++; $display("FAIL ramp_44: got %0d want 24", gotData[24]); end
        nChecks++; if (doneCnt !== 1) begin nFail++; $display("FAIL ramp_done_count: got %0d want 1", doneCnt); end
    endtask

    task test_timing;
        readyS = 1'b1;
        runPassS(800);
        for (int i = 0; i < 25; i++) begin
            nChecks++; if (gotCyc[i] !== 28 * (i + 1)) begin nFail++; $display("FAIL timing_cycle[%0d]: got %0d want %0d", i, gotCyc[i], 28 * (i + 1)); end
            nChecks++; if (gotAddr[i] !== i) begin nFail++; $display("FAIL timing_addr[%0d]: got %0d want %0d", i, gotAddr[i], i); end
        end
        nChecks++; if (doneCyc !== 701) begin nFail++; $display("FAIL timing_done_cycle: got %0d want 701", doneCyc); end
        nChecks++; if (busyFirst !== 1'b1) begin nFail++; $display("FAIL timing_busy_start: got %b want 1", busyFirst); end
        nChecks++; if (busyAtDone !== 1'b0) begin nFail++; $display("FAIL timing_busy_done: got %b want 0", busyAtDone); end
    endtask

    task test_backpressure;
        int  rdCyc;
        bit  found;
        readyS = 1'b0;
        startS = 1'b1;
        found  = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            startS = 1'b0;
            if (validS) begin found = 1'b1; break; end
        end
        nChecks++; if (found !== 1'b1) begin nFail++; $display("FAIL bp_first_valid: got timeout want valid"); end
        for (int c = 0; c < 10; c++) begin
            nChecks++; if (validS !== 1'b1) begin nFail++; $display("FAIL bp_valid c%0d: got %b want 1", c, validS); end
            nChecks++; if (dataS !== 16'd12) begin nFail++; $display("FAIL bp_data c%0d: got %0d want 12", c, dataS); end
            nChecks++; if (addrS !== 5'd0) begin nFail++; $display("FAIL bp_addr c%0d: got %0d want 0", c, addrS); end
            nChecks++; if (rdEnS !== 1'b0) begin nFail++; $display("FAIL bp_rd_en c%0d: got %b want 0", c, rdEnS); end
            @(negedge clk);
        end
        readyS = 1'b1;
        @(negedge clk);
        nChecks++; if (validS !== 1'b0) begin nFail++; $display("FAIL bp_valid_drop: got %b want 0", validS); end
        // Pixel (0,1): first in-bounds tap is k=11, i.e. the 12th FETCH cycle.
        rdCyc = -1;
        for (int m = 1; m <= 30; m++) begin
            if (rdEnS) begin rdCyc = m; break; end
            @(negedge clk);
        end
        nChecks++; if (rdCyc !== 12) begin nFail++; $display("FAIL bp_next_fetch: got %0d want 12", rdCyc); end
        nChecks++; if (rdAddrS !== 5'd0) begin nFail++; $display("FAIL bp_next_rd_addr: got %0d want 0", rdAddrS); end
        found = 1'b0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (doneS) begin found = 1'b1; break; end
        end
        nChecks++; if (found !== 1'b1) begin nFail++; $display("FAIL bp_done: got timeout want done"); end
        repeat (2) @(negedge clk);
    endtask

    task test_reset_midpass;
        readyS = 1'b1;
        startS = 1'b1;
        // n=204 is FETCH tap 7 of pixel 7, with reads in flight.
        for (int n = 1; n <= 204; n++) begin
            @(negedge clk);
            startS = 1'b0;
        end
        nChecks++; if (busyS !== 1'b1) begin nFail++; $display("FAIL mid_busy_before: got %b want 1", busyS); end
        nChecks++; if (addrS !== 5'd6) begin nFail++; $display("FAIL mid_addr_before: got %0d want 6", addrS); end
        nChecks++; if (rdEnS !== 1'b1) begin nFail++; $display("FAIL mid_rd_en_before: got %b want 1", rdEnS); end
        reset = 1'b1;
        @(negedge clk);
        nChecks++; if (busyS !== 1'b0) begin nFail++; $display("FAIL mid_busy: got %b want 0", busyS); end
        nChecks++; if (rdEnS !== 1'b0) begin nFail++; $display("FAIL mid_rd_en: got %b want 0", rdEnS); end
        nChecks++; if (validS !== 1'b0) begin nFail++; $display("FAIL mid_valid: got %b want 0", validS); end
        nChecks++; if (winS !== allPad) begin nFail++; $display("FAIL mid_win: got %h want all 8000", winS); end
        reset = 1'b0;
        @(negedge clk);
        nChecks++; if (winS !== allPad) begin nFail++; $display("FAIL mid_inflight: got %h want all 8000", winS); end
        runPassS(800);
        nChecks++; if (nOut !== 25) begin nFail++; $display("FAIL mid_replay_count: got %0d want 25", nOut); end
        for (int i = 0; i < 25; i++) begin
            nChecks++; if (gotAddr[i] !== i || gotData[i] !== expRamp(i)) begin
                nFail++; $display("FAIL mid_replay[%0d]: got addr %0d data %0d want addr %0d data %0d", i, gotAddr[i], gotData[i], i, expRamp(i));
            end
        end
    endtask

    task test_extremes;
        for (int i = 0; i < 32; i++) memS[i] = 16'h8000;
        memS[18] = 16'h7FFF;
        readyS = 1'b1;
        runPassS(800);
        nChecks++; if (nOut !== 25) begin nFail++; $display("FAIL ext_count: got %0d want 25", nOut); end
        for (int i = 0; i < 25; i++) begin
            nChecks++; if (gotData[i] !== expPeak(i)) begin nFail++; $display("FAIL ext_data[%0d]: got %h want %h", i, gotData[i], expPeak(i)); end
        end
    endtask

    task test_corner_padding;
        int  rdCount, padCount;
        bit  found;
        for (int i = 0; i < 512; i++) memL[i] = 16'hFFFB;
        readyL  = 1'b0;
        startL  = 1'b1;
        rdCount = 0;
        found   = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            startL = 1'b0;
            if (rdEnL) rdCount++;
            if (validL) begin found = 1'b1; break; end
        end
        padCount = 0;
        for (int t = 0; t < 25; t++) if (winL[t*DW +: DW] == 16'h8000) padCount++;
        nChecks++; if (found !== 1'b1) begin nFail++; $display("FAIL corner_valid: got timeout want valid"); end
        nChecks++; if (rdCount !== 9) begin nFail++; $display("FAIL corner_reads: got %0d want 9", rdCount); end
        nChecks++; if (padCount !== 16) begin nFail++; $display("FAIL corner_pads: got %0d want 16", padCount); end
        nChecks++; if (dataL !== 16'hFFFB) begin nFail++; $display("FAIL corner_data: got %h want fffb", dataL); end
        nChecks++; if (addrL !== 9'd0) begin nFail++; $display("FAIL corner_addr: got %0d want 0", addrL); end
        readyL = 1'b1;
        found  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (validL) begin found = 1'b1; break; end
        end
        nChecks++; if (found !== 1'b1) begin nFail++; $display("FAIL pix1_valid: got timeout want valid"); end
        // Pixel (0,2) is a top-edge pixel: two padded rows of five.
        rdCount = 0;
        found   = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdEnL) rdCount++;
            if (validL) begin found = 1'b1; break; end
        end
        padCount = 0;
        for (int t = 0; t < 25; t++) if (winL[t*DW +: DW] == 16'h8000) padCount++;
        nChecks++; if (found !== 1'b1) begin nFail++; $display("FAIL edge_valid: got timeout want valid"); end
        nChecks++; if (addrL !== 9'd2) begin nFail++; $display("FAIL edge_addr: got %0d want 2", addrL); end
        nChecks++; if (rdCount !== 15) begin nFail++; $display("FAIL edge_reads: got %0d want 15", rdCount); end
        nChecks++; if (padCount !== 10) begin nFail++; $display("FAIL edge_pads: got %0d want 10", padCount); end
        nChecks++; if (dataL !== 16'hFFFB) begin nFail++; $display("FAIL edge_data: got %h want fffb", dataL); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        allPad = {25{16'h8000}};
        reset  = 1'b1;
        startS = 1'b0; startL = 1'b0; readyS = 1'b1; readyL = 1'b1;
        for (int i = 0; i < 32; i++) memS[i] = '0;
        for (int i = 0; i < 512; i++) memL[i] = '0;
        test_reset;
        test_window_values;
        test_timing;
        test_backpressure;
        test_reset_midpass;
        test_extremes;
        test_corner_padding;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
